// File: rtl/piso_sched_pkg.sv
// Shared definitions for the round-robin PISO scheduler: state encoding,
// default parameters and a constant-evaluable clog2.
package piso_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_GAP   = 1;

  // Never returns less than 1 so single-entry vectors still get a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the
// pointer, wrapping modulo N_REQ. The pointer register lives in the parent.
module rr_arbiter
  import piso_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int PW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    idx_o,
  output logic             any_o
);

  int            sum;
  logic [PW-1:0] cand;

  // Explicit wrap keeps the candidate in range when N_REQ is not a power of 2.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = int'(ptr_i) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = PW'(sum);
      if (en_i && !any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/iiitb_piso_sched.sv
// Round-robin scheduler sharing one PISO serializer between N_REQ producers:
// accepts a word, pulses load, then times the shift window and inter-frame gap.
module iiitb_piso_sched
  import piso_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP,
  localparam int PW   = clog2(N_REQ),
  localparam int CW   = clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   piso_load,
  output logic [WIDTH-1:0]       piso_data,
  output logic                   frame_active,
  output logic                   frame_last,
  output logic [PW-1:0]          grant_id,
  output logic                   busy
);

  state_e           state_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       gap_q;
  logic [WIDTH-1:0] data_q;
  logic             load_q, active_q, last_q, busy_q;

  logic             arbEn;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gntIdx;
  logic             anyGrant;
  logic [WIDTH-1:0] selWord;

  // Offering ready only in IDLE and out of reset means any grant is an accept.
  assign arbEn = rst && (state_q == ST_IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (arbEn),
    .gnt_o (gnt),
    .idx_o (gntIdx),
    .any_o (anyGrant)
  );

  always_comb begin
    ptr_d   = (gntIdx == PW'(N_REQ - 1)) ? '0 : gntIdx + 1'b1;
    selWord = req_data[int'(gntIdx)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      load_q   <= 1'b0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (anyGrant) begin
            data_q  <= selWord;
            grant_q <= gntIdx;
            ptr_q   <= ptr_d;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          load_q   <= 1'b0;
          active_q <= 1'b1;
          last_q   <= (WIDTH == 1);
          cnt_q    <= '0;
          state_q  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            active_q <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            if (GAP > 0) begin
              gap_q   <= '0;
              state_q <= ST_GAP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            last_q <= (cnt_q == CW'(WIDTH - 2));
          end
        end
        ST_GAP: begin
          if (gap_q == 4'(GAP - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = gnt;
  assign piso_load    = load_q;
  assign piso_data    = data_q;
  assign frame_active = active_q;
  assign frame_last   = last_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_iiitb_piso_sched.sv
// Directed bench for iiitb_piso_sched: default build (GAP=1) plus a GAP=0
// build for back-to-back frame spacing.
module tb_iiitb_piso_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic        pisoLoad, frameActive, frameLast, busy;
  logic [7:0]  pisoData;
  logic [1:0]  grantId;

  logic [3:0]  valid0;
  logic [31:0] data0;
  logic [3:0]  ready0;
  logic        load0, fa0, fl0, busy0;
  logic [7:0]  pdata0;
  logic [1:0]  gid0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iiitb_piso_sched #(.N_REQ(4), .WIDTH(8), .GAP(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (reqValid),
    .req_data     (reqData),
    .req_ready    (reqReady),
    .piso_load    (pisoLoad),
    .piso_data    (pisoData),
    .frame_active (frameActive),
    .frame_last   (frameLast),
    .grant_id     (grantId),
    .busy         (busy)
  );

  iiitb_piso_sched #(.N_REQ(4), .WIDTH(8), .GAP(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (valid0),
    .req_data     (data0),
    .req_ready    (ready0),
    .piso_load    (load0),
    .piso_data    (pdata0),
    .frame_active (fa0),
    .frame_last   (fl0),
    .grant_id     (gid0),
    .busy         (busy0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
    reqValid = valid;
    reqData  = data;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Called in the cycle the accept is expected; walks LOAD, SHIFT, GAP and
  // returns in the following IDLE cycle.
  task automatic runFrame(input int idx, input logic [7:0] word, input bit dropAfter);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    #1;
    checkOutput("accept_ready", reqReady, oh);
    step();
    if (dropAfter) reqValid[idx] = 1'b0;
    checkOutput("load_pulse", pisoLoad, 1'b1);
    checkOutput("load_data", pisoData, word);
    checkOutput("load_grant", grantId, idx[1:0]);
    checkOutput("load_busy", busy, 1'b1);
    checkOutput("load_active", frameActive, 1'b0);
    checkOutput("load_ready", reqReady, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("shift_active", frameActive, 1'b1);
      checkOutput("shift_last", frameLast, (i == 7));
      checkOutput("shift_load", pisoLoad, 1'b0);
      checkOutput("shift_ready", reqReady, 4'b0000);
    end
    step();
    checkOutput("gap_active", frameActive, 1'b0);
    checkOutput("gap_last", frameLast, 1'b0);
    checkOutput("gap_busy", busy, 1'b1);
    checkOutput("gap_ready", reqReady, 4'b0000);
    checkOutput("gap_grant", grantId, idx[1:0]);
    step();
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_load", pisoLoad, 1'b0);
  endtask

  initial begin
    rst    = 1'b0;
    valid0 = 4'b0000;
    data0  = 32'h0;
    applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});

    $display("[TB] reset hold with all requesters valid");
    repeat (3) begin
      step();
      checkOutput("rst_ready", reqReady, 4'b0000);
      checkOutput("rst_load", pisoLoad, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
    end
    checkOutput("rst_grant", grantId, 2'd0);
    checkOutput("rst_data", pisoData, 8'h00);
    checkOutput("rst_active", frameActive, 1'b0);

    step();
    rst = 1'b1;
    $display("[TB] round robin with all four valid");
    runFrame(0, 8'h11, 1'b0);
    runFrame(1, 8'h22, 1'b0);
    runFrame(2, 8'h33, 1'b0);
    runFrame(3, 8'h44, 1'b0);
    runFrame(0, 8'h11, 1'b0);
    runFrame(1, 8'h22, 1'b0);
    runFrame(2, 8'h33, 1'b0);
    runFrame(3, 8'h44, 1'b0);

    $display("[TB] pointer wrap and skip of idle requester");
    reqValid = 4'b0101;
    runFrame(0, 8'h11, 1'b0);
    runFrame(2, 8'h33, 1'b1);
    reqValid = 4'b0000;

    $display("[TB] single frame from requester 2");
    applyStimulus(4'b0100, {8'h44, 8'h0F, 8'h22, 8'h11});
    runFrame(2, 8'h0F, 1'b1);
    checkOutput("single_after_ready", reqReady, 4'b0000);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(4'b0010, {8'h44, 8'h0F, 8'hFF, 8'h11});
    #1;
    checkOutput("midrst_accept", reqReady, 4'b0010);
    step();
    reqValid = 4'b0000;
    checkOutput("midrst_load", pisoLoad, 1'b1);
    checkOutput("midrst_data", pisoData, 8'hFF);
    repeat (4) step();
    checkOutput("midrst_shift4", frameActive, 1'b1);
    rst = 1'b0;
    step();
    checkOutput("midrst_load0", pisoLoad, 1'b0);
    checkOutput("midrst_data0", pisoData, 8'h00);
    checkOutput("midrst_active0", frameActive, 1'b0);
    checkOutput("midrst_last0", frameLast, 1'b0);
    checkOutput("midrst_grant0", grantId, 2'd0);
    checkOutput("midrst_busy0", busy, 1'b0);
    checkOutput("midrst_ready0", reqReady, 4'b0000);
    rst = 1'b1;
    #1;
    checkOutput("release_ready", reqReady, 4'b0000);
    step();
    checkOutput("release_noreplay_load", pisoLoad, 1'b0);
    checkOutput("release_noreplay_busy", busy, 1'b0);
    applyStimulus(4'b1001, {8'h44, 8'h0F, 8'hFF, 8'h11});
    runFrame(0, 8'h11, 1'b1);
    reqValid = 4'b0000;

    $display("[TB] GAP=0 build back-to-back frames");
    valid0 = 4'b0011;
    data0  = {8'h00, 8'h00, 8'h00, 8'hFF};
    #1;
    checkOutput("g0_accept0", ready0, 4'b0001);
    step();
    valid0[0] = 1'b0;
    checkOutput("g0_load0", load0, 1'b1);
    checkOutput("g0_data0", pdata0, 8'hFF);
    repeat (8) step();
    checkOutput("g0_last", fl0, 1'b1);
    checkOutput("g0_active", fa0, 1'b1);
    step();
    checkOutput("g0_idle_busy", busy0, 1'b0);
    checkOutput("g0_idle_load", load0, 1'b0);
    checkOutput("g0_accept1", ready0, 4'b0010);
    step();
    valid0 = 4'b0000;
    checkOutput("g0_load1", load0, 1'b1);
    checkOutput("g0_data1", pdata0, 8'h00);
    checkOutput("g0_grant1", gid0, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
